slow_hold_timer: RTL and testbench

- Consumes the slow-mode configuration flags and timeout nibble produced by the slow-configuration register block.
- Watches bus cycles and chip selects to decide when the accelerated CPU must drop to stock speed.
- On an access to an enabled slow device, asserts SlowReq for the access plus a programmable hold-off of SlowTimeout ticks.
- Feeds the clock-switch / bus-timing logic downstream.

---
 rtl/slow_pkg.sv | 14 +
 rtl/slow_hold_timer_if.sv | 48 ++++
 rtl/slow_tick_prescaler.sv | 41 ++++
 rtl/slow_hold_timer.sv | 122 ++++++++++++
 tb/tb_slow_hold_timer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slow_pkg.sv
// Shared types and constants for the slow-mode hold-off timer.
package slow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        COUNT = 2'd2
    } slowState_t;

    localparam int TIMEOUT_W        = 4;
    localparam int NUM_DEV          = 6;
    localparam int DEFAULT_TICK_DIV = 256;

endpackage

// File: rtl/slow_hold_timer_if.sv
// Bus-cycle, chip-select and slow-config bundle feeding slow_hold_timer.
// Carries ForceSlow only when SLOW_FORCE_EN is defined.
interface slow_hold_timer_if;
    import slow_pkg::*;

    logic                 BACT;
    logic                 IACKCS;
    logic                 VIACS;
    logic                 IWMCS;
    logic                 SCCCS;
    logic                 SCSICS;
    logic                 SndCSWR;
    logic                 SlowIACK;
    logic                 SlowVIA;
    logic                 SlowIWM;
    logic                 SlowSCC;
    logic                 SlowSCSI;
    logic                 SlowSnd;
    logic                 SlowClockGate;
    logic [TIMEOUT_W-1:0] SlowTimeout;
`ifdef SLOW_FORCE_EN
    logic                 ForceSlow;
`endif
    logic                 SlowReq;
    logic                 SlowGate;
    logic                 SlowBusy;

    modport master (
`ifdef SLOW_FORCE_EN
        output ForceSlow,
`endif
        output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR,
        output SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
        output SlowClockGate, SlowTimeout,
        input  SlowReq, SlowGate, SlowBusy
    );

    modport slave (
`ifdef SLOW_FORCE_EN
        input  ForceSlow,
`endif
        input  BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR,
        input  SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
        input  SlowClockGate, SlowTimeout,
        output SlowReq, SlowGate, SlowBusy
    );

endinterface

// File: rtl/slow_tick_prescaler.sv
// Divides CLK down to one tick pulse every TICK_DIV cycles while enabled.
// The count is held at zero whenever it is disabled or cleared.
module slow_tick_prescaler #(
    parameter int TICK_DIV = slow_pkg::DEFAULT_TICK_DIV,
    parameter int TICK_W   = 8
) (
    input  logic CLK,
    input  logic POR,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] countReg;
    logic [TICK_W-1:0] countNext;

    always_comb begin
        countNext = countReg;
        if (clear || !enable) begin
            countNext = '0;
        end else if (countReg == LAST) begin
            countNext = '0;
        end else begin
            countNext = countReg + TICK_W'(1);
        end
    end

    // A clear outranks the wrap so a re-hit never also produces a tick.
    assign tick = enable && !clear && (countReg == LAST);

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            countReg <= '0;
        end else begin
            countReg <= countNext;
        end
    end

endmodule

// File: rtl/slow_hold_timer.sv
// Holds SlowReq for the duration of a slow-device access plus SlowTimeout ticks.
// Optional SLOW_FORCE_EN adds a ForceSlow input that also raises SlowReq/SlowGate.
module slow_hold_timer
    import slow_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int TICK_W   = 8
) (
    input  logic             CLK,
    input  logic             POR,
    slow_hold_timer_if.slave bus
);

    slowState_t           stateReg;
    slowState_t           stateNext;
    logic [TIMEOUT_W-1:0] countReg;
    logic [TIMEOUT_W-1:0] countNext;
    logic [NUM_DEV-1:0]   devSel;
    logic [NUM_DEV-1:0]   devEn;
    logic [NUM_DEV-1:0]   devHit;
    logic                 hit;
    logic                 tick;
    logic                 prescClear;
    logic                 prescEnable;
    logic                 reqNext;
    logic                 slowReqReg;
    logic                 slowGateReg;
    logic                 slowBusyReg;

    assign devSel = {bus.SndCSWR, bus.SCSICS, bus.SCCCS, bus.IWMCS, bus.VIACS, bus.IACKCS};
    assign devEn  = {bus.SlowSnd, bus.SlowSCSI, bus.SlowSCC, bus.SlowIWM, bus.SlowVIA, bus.SlowIACK};

    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev_hit
            assign devHit[gi] = devSel[gi] & devEn[gi];
        end
    endgenerate

    assign hit         = bus.BACT & (|devHit);
    assign prescEnable = (stateReg == COUNT);

    slow_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .CLK    (CLK),
        .POR    (POR),
        .clear  (prescClear),
        .enable (prescEnable),
        .tick   (tick)
    );

    always_comb begin
        stateNext  = stateReg;
        countNext  = countReg;
        prescClear = 1'b0;
        case (stateReg)
            IDLE: begin
                if (hit) begin
                    stateNext = HOLD;
                    countNext = bus.SlowTimeout;
                end
            end
            HOLD: begin
                if (!bus.BACT) begin
                    if (countReg != '0) begin
                        stateNext  = COUNT;
                        prescClear = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            COUNT: begin
                // A new slow access restarts the whole hold-off, even on a tick edge.
                if (hit) begin
                    stateNext  = HOLD;
                    countNext  = bus.SlowTimeout;
                    prescClear = 1'b1;
                end else if (tick) begin
                    if (countReg != '0) begin
                        countNext = countReg - TIMEOUT_W'(1);
                    end
                    if (countReg <= TIMEOUT_W'(1)) begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                countNext = '0;
            end
        endcase
    end

`ifdef SLOW_FORCE_EN
    assign reqNext = (stateNext != IDLE) | bus.ForceSlow;
`else
    assign reqNext = (stateNext != IDLE);
`endif

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            stateReg    <= IDLE;
            countReg    <= '0;
            slowReqReg  <= 1'b0;
            slowGateReg <= 1'b0;
            slowBusyReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            countReg    <= countNext;
            slowReqReg  <= reqNext;
            slowGateReg <= reqNext & bus.SlowClockGate;
            slowBusyReg <= (stateNext == COUNT);
        end
    end

    assign bus.SlowReq  = slowReqReg;
    assign bus.SlowGate = slowGateReg;
    assign bus.SlowBusy = slowBusyReg;

endmodule

// File: tb/tb_slow_hold_timer.sv
// Randomized and directed checks of slow_hold_timer (TICK_DIV=4) against a cycle-count model.
module tb_slow_hold_timer;

    localparam int TB_TICK_DIV = 4;

    logic CLK;
    logic POR;
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0=idle, 1=holding during access, 2=counting down remaining cycles
    int   mPhase;
    int   mLatch;
    int   mRem;
    logic eReq;
    logic eGate;
    logic eBusy;

    slow_hold_timer_if bus();

    slow_hold_timer #(
        .TICK_DIV (TB_TICK_DIV),
        .TICK_W   (2)
    ) dut (
        .CLK (CLK),
        .POR (POR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        mPhase = 0; mLatch = 0; mRem = 0;
        eReq = 1'b0; eGate = 1'b0; eBusy = 1'b0;
    endtask

    task automatic model_edge();
        logic h;
        logic f;
        h = bus.BACT && ((bus.IACKCS && bus.SlowIACK) || (bus.VIACS && bus.SlowVIA) ||
                         (bus.IWMCS && bus.SlowIWM) || (bus.SCCCS && bus.SlowSCC) ||
                         (bus.SCSICS && bus.SlowSCSI) || (bus.SndCSWR && bus.SlowSnd));
        f = 1'b0;
`ifdef SLOW_FORCE_EN
        f = bus.ForceSlow;
`endif
        case (mPhase)
            0: if (h) begin mPhase = 1; mLatch = int'(bus.SlowTimeout); end
            1: if (!bus.BACT) begin
                   if (mLatch != 0) begin mPhase = 2; mRem = mLatch * TB_TICK_DIV; end
                   else mPhase = 0;
               end
            default: if (h) begin mPhase = 1; mLatch = int'(bus.SlowTimeout); end
                     else begin mRem--; if (mRem == 0) mPhase = 0; end
        endcase
        eReq  = (mPhase != 0) || f;
        eGate = eReq && bus.SlowClockGate;
        eBusy = (mPhase == 2);
    endtask

    // One clock: model follows inputs sampled at the edge, outputs examined 1 time unit later
    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic bus_idle();
        bus.BACT = 0; bus.IACKCS = 0; bus.VIACS = 0; bus.IWMCS = 0;
        bus.SCCCS = 0; bus.SCSICS = 0; bus.SndCSWR = 0;
    endtask

    task automatic enables_off();
        bus.SlowIACK = 0; bus.SlowVIA = 0; bus.SlowIWM = 0;
        bus.SlowSCC = 0; bus.SlowSCSI = 0; bus.SlowSnd = 0;
    endtask

    task automatic test_reset();
        POR = 1'b1;
        bus_idle(); enables_off();
        bus.SlowClockGate = 1'b1; bus.SlowTimeout = 4'd5;
`ifdef SLOW_FORCE_EN
        bus.ForceSlow = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({bus.SlowReq, bus.SlowGate, bus.SlowBusy} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs got=%b exp=000", {bus.SlowReq, bus.SlowGate, bus.SlowBusy});
        end
        POR = 1'b0;
        bus.BACT = 1; bus.IACKCS = 1; bus.VIACS = 1; bus.IWMCS = 1;
        bus.SCCCS = 1; bus.SCSICS = 1; bus.SndCSWR = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (bus.SlowReq !== 1'b0) begin
                errors++; $display("FAIL no_enable_req cyc=%0d got=%b exp=0", i, bus.SlowReq);
            end
        end
        bus_idle();
        cycle();
    endtask

    task automatic test_holdoff();
        int reqCnt = 0;
        int busyCnt = 0;
        bus.SlowVIA = 1; bus.SlowTimeout = 4'd3; bus.SlowClockGate = 0;
        bus.BACT = 1; bus.VIACS = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (bus.SlowReq !== 1'b1 || bus.SlowBusy !== 1'b0) begin
                errors++; $display("FAIL holdoff_access cyc=%0d req=%b busy=%b exp req=1 busy=0", i, bus.SlowReq, bus.SlowBusy);
            end
        end
        bus_idle();
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (bus.SlowReq === 1'b1) reqCnt++;
            if (bus.SlowBusy === 1'b1) busyCnt++;
            if (bus.SlowReq !== 1'b1) break;
        end
        checks++;
        if (reqCnt != 12) begin
            errors++; $display("FAIL holdoff_req_len got=%0d exp=12", reqCnt);
        end
        checks++;
        if (busyCnt != 12) begin
            errors++; $display("FAIL holdoff_busy_len got=%0d exp=12", busyCnt);
        end
        enables_off();
    endtask

    task automatic test_zero_timeout();
        int  reqCnt = 0;
        logic busySeen = 1'b0;
        bus.SlowSCC = 1; bus.SlowTimeout = 4'd0;
        bus.BACT = 1; bus.SCCCS = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (bus.SlowReq === 1'b1) reqCnt++;
            if (bus.SlowBusy !== 1'b0) busySeen = 1'b1;
        end
        bus_idle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.SlowReq === 1'b1) reqCnt++;
            if (bus.SlowBusy !== 1'b0) busySeen = 1'b1;
        end
        checks++;
        if (reqCnt != 4) begin
            errors++; $display("FAIL zero_timeout_req_len got=%0d exp=4", reqCnt);
        end
        checks++;
        if (busySeen !== 1'b0) begin
            errors++; $display("FAIL zero_timeout_busy got=%b exp=0", busySeen);
        end
        enables_off();
    endtask

    task automatic test_rehit();
        int  tailCnt = 0;
        logic gap = 1'b0;
        bus.SlowIWM = 1; bus.SlowTimeout = 4'd2;
        bus.BACT = 1; bus.IWMCS = 1;
        repeat (3) begin cycle(); if (bus.SlowReq !== 1'b1) gap = 1'b1; end
        bus_idle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (bus.SlowReq !== 1'b1) gap = 1'b1;
            checks++;
            if (bus.SlowBusy !== 1'b1) begin
                errors++; $display("FAIL rehit_count_busy cyc=%0d got=%b exp=1", i, bus.SlowBusy);
            end
        end
        bus.BACT = 1; bus.IWMCS = 1;
        repeat (2) begin cycle(); if (bus.SlowReq !== 1'b1) gap = 1'b1; end
        checks++;
        if (bus.SlowBusy !== 1'b0) begin
            errors++; $display("FAIL rehit_back_to_hold busy=%b exp=0", bus.SlowBusy);
        end
        bus_idle();
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (bus.SlowReq !== 1'b1) break;
            tailCnt++;
        end
        checks++;
        if (gap !== 1'b0) begin
            errors++; $display("FAIL rehit_continuous gap=%b exp=0", gap);
        end
        checks++;
        if (tailCnt != 8) begin
            errors++; $display("FAIL rehit_tail_len got=%0d exp=8", tailCnt);
        end
        enables_off();
    endtask

    task automatic test_clock_gate();
        logic cg;
        bus.SlowSCSI = 1; bus.SlowTimeout = 4'd4;
        bus.BACT = 1; bus.SCSICS = 1;
        cg = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cg = ~cg;
            bus.SlowClockGate = cg;
            cycle();
            checks++;
            if (bus.SlowGate !== cg || bus.SlowReq !== 1'b1) begin
                errors++; $display("FAIL gate_follow cyc=%0d gate=%b req=%b exp gate=%b req=1", i, bus.SlowGate, bus.SlowReq, cg);
            end
        end
        bus.SlowClockGate = 1;
        bus_idle();
        repeat (3) cycle();
        checks++;
        if ({bus.SlowReq, bus.SlowGate, bus.SlowBusy} !== 3'b111) begin
            errors++; $display("FAIL gate_mid_count got=%b exp=111", {bus.SlowReq, bus.SlowGate, bus.SlowBusy});
        end
        POR = 1'b1;
        #1;
        checks++;
        if ({bus.SlowReq, bus.SlowGate, bus.SlowBusy} !== 3'b000) begin
            errors++; $display("FAIL async_por got=%b exp=000", {bus.SlowReq, bus.SlowGate, bus.SlowBusy});
        end
        model_reset();
        #1 POR = 1'b0;
        cycle();
        checks++;
        if (bus.SlowReq !== 1'b0) begin
            errors++; $display("FAIL post_por_idle got=%b exp=0", bus.SlowReq);
        end
        enables_off();
    endtask

`ifdef SLOW_FORCE_EN
    task automatic test_force();
        bus.SlowClockGate = 1;
        bus.ForceSlow = 1;
        cycle();
        checks++;
        if ({bus.SlowReq, bus.SlowGate, bus.SlowBusy} !== 3'b110) begin
            errors++; $display("FAIL force_on got=%b exp=110", {bus.SlowReq, bus.SlowGate, bus.SlowBusy});
        end
        bus.ForceSlow = 0;
        cycle();
        checks++;
        if (bus.SlowReq !== 1'b0) begin
            errors++; $display("FAIL force_off got=%b exp=0", bus.SlowReq);
        end
    endtask
`endif

    task automatic test_random();
        logic [5:0] sel;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                {bus.SlowIACK, bus.SlowVIA, bus.SlowIWM, bus.SlowSCC, bus.SlowSCSI, bus.SlowSnd} = 6'($urandom);
                bus.SlowTimeout = 4'($urandom_range(0, 3));
            end
            bus.BACT = ($urandom_range(0, 2) == 0);
            sel = ($urandom_range(0, 3) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
            {bus.IACKCS, bus.VIACS, bus.IWMCS, bus.SCCCS, bus.SCSICS, bus.SndCSWR} = sel;
            bus.SlowClockGate = 1'($urandom);
`ifdef SLOW_FORCE_EN
            bus.ForceSlow = ($urandom_range(0, 19) == 0);
`endif
            cycle();
            checks++;
            if (bus.SlowReq !== eReq || bus.SlowGate !== eGate || bus.SlowBusy !== eBusy) begin
                errors++;
                $display("FAIL random cyc=%0d got req/gate/busy=%b%b%b exp=%b%b%b",
                         i, bus.SlowReq, bus.SlowGate, bus.SlowBusy, eReq, eGate, eBusy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_holdoff();
        test_zero_timeout();
        test_rehit();
        test_clock_gate();
`ifdef SLOW_FORCE_EN
        test_force();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
